// File: rtl/pump_scheduler.sv
// pump_scheduler -- two-pump tank level scheduler.
//
// Reads the lower (inputI) and upper (inputS) level sensors and decides which
// of the two pumps runs. The lead pump rotates on every completed fill. The
// second pump is brought in on low level or when a single-pump fill runs too
// long. Every fill configuration is held for a minimum time. An inconsistent
// sensor pair (upper wet, lower dry) latches an alarm until the sensors have
// read consistent for three samples in a row.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous reset, active low
//   inputI    lower sensor, 1 = water above lower mark (asynchronous)
//   inputS    upper sensor, 1 = water above upper mark (asynchronous)
//   outputB0  pump 0 enable
//   outputB1  pump 1 enable
//   alarm     sensor fault indication
//   lead      current lead pump (0 = B0, 1 = B1)
module pump_scheduler #(
   parameter int MIN_ON  = 4,
   parameter int MAX_ONE = 20,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic inputI,
   input  logic inputS,
   output logic outputB0,
   output logic outputB1,
   output logic alarm,
   output logic lead
);

   typedef enum logic [1:0] {IDLE, FILL_ONE, FILL_BOTH, ERROR} state_t;

   localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
   localparam logic [CNT_W-1:0] MAX_ONE_C = CNT_W'(MAX_ONE);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   // Synchronizers reset to "full" so the pumps stay off until real samples
   // have propagated through both stages.
   logic i_s1, i_s2, s_s1, s_s2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_s1 <= 1'b1;
         i_s2 <= 1'b1;
         s_s1 <= 1'b1;
         s_s2 <= 1'b1;
      end else begin
         i_s1 <= inputI;
         i_s2 <= i_s1;
         s_s1 <= inputS;
         s_s2 <= s_s1;
      end
   end

   state_t           state, state_nxt;
   logic             lead_q, lead_nxt;
   logic             assist, assist_nxt;   // 1 = FILL_BOTH entered on timeout
   logic [CNT_W-1:0] cnt;
   logic [1:0]       cons, cons_nxt;        // consecutive clean samples in ERROR

   logic fault, dwell_ok;
   assign fault    = s_s2 & ~i_s2;
   assign dwell_ok = (cnt >= MIN_ON_C);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         lead_q <= 1'b0;
         assist <= 1'b0;
         cons   <= 2'd0;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         lead_q <= lead_nxt;
         assist <= assist_nxt;
         cons   <= cons_nxt;
         if (state_nxt != state) cnt <= '0;
         else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
   end

   // Branch order inside each state encodes the priority
   // fault > low-level escalation > full exit > assist timeout > de-escalation.
   always_comb begin
      state_nxt  = state;
      lead_nxt   = lead_q;
      assist_nxt = assist;
      cons_nxt   = 2'd0;
      if (fault) begin
         state_nxt = ERROR;
      end else begin
         unique case (state)
            IDLE: begin
               if (!i_s2) begin
                  state_nxt  = FILL_BOTH;
                  assist_nxt = 1'b0;
               end else if (!s_s2) begin
                  state_nxt = FILL_ONE;
               end
            end
            FILL_ONE: begin
               if (!i_s2) begin
                  state_nxt  = FILL_BOTH;
                  assist_nxt = 1'b0;
               end else if (s_s2 && dwell_ok) begin
                  state_nxt = IDLE;
                  lead_nxt  = ~lead_q;
               end else if (!s_s2 && cnt >= MAX_ONE_C) begin
                  state_nxt  = FILL_BOTH;
                  assist_nxt = 1'b1;
               end
            end
            FILL_BOTH: begin
               if (s_s2 && dwell_ok) begin
                  state_nxt = IDLE;
                  lead_nxt  = ~lead_q;
               end else if (i_s2 && dwell_ok && !assist) begin
                  state_nxt = FILL_ONE;
               end
            end
            ERROR: begin
               // This clean sample is the third in a row: leave now.
               if (cons == 2'd2) state_nxt = IDLE;
               else              cons_nxt  = cons + 2'd1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Moore decode of registered state only.
   always_comb begin
      outputB0 = 1'b0;
      outputB1 = 1'b0;
      alarm    = 1'b0;
      unique case (state)
         FILL_ONE: begin
            outputB0 = ~lead_q;
            outputB1 = lead_q;
         end
         FILL_BOTH: begin
            outputB0 = 1'b1;
            outputB1 = 1'b1;
         end
         ERROR:   alarm = 1'b1;
         default: ;
      endcase
   end

   assign lead = lead_q;

endmodule

// File: doc/pump_scheduler.md
# pump_scheduler

Two-pump tank level scheduler. It reads the lower (I) and upper (S) level sensors and decides which of pumps B0/B1 run. It rotates the lead pump between fill cycles, brings in the second pump on low level or on a slow fill, enforces a minimum run time, and latches an alarm on inconsistent sensors. It sits between the raw sensor inputs and the pump drivers, and replaces the single fixed-priority Moore controller for installations with two pumps.

## Interface
- MIN_ON, 4: minimum cycles a pump configuration is held before the controller may leave it.
- MAX_ONE, 20: maximum cycles in single-pump fill before the second pump assists.
- CNT_W, 8: width of the dwell counter; MIN_ON and MAX_ONE must each be < 2^CNT_W.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; asserting it forces all state to reset values immediately.
- inputI  input  1  lower sensor; 1 = water above the lower mark; asynchronous to clk.
- inputS  input  1  upper sensor; 1 = water above the upper mark; asynchronous to clk.
- outputB0  output  1  pump 0 enable.
- outputB1  output  1  pump 1 enable.
- alarm  output  1  sensor fault indication.
- lead  output  1  current lead pump (0 = B0, 1 = B1).

## Operation
- Both sensors pass through 2-flop synchronizers. Reset value of both sync stages is 1, meaning "full", so pumps stay off.
- Dwell counter cnt: cleared to 0 on every state change, otherwise +1 per cycle, saturating at 2^CNT_W-1. The first cycle in a state has cnt=0.
- Fault: synced S=1 with synced I=0. It is checked in every state and has the highest priority. It goes to ERROR on the next edge regardless of cnt.
- States, with outputs as a Moore decode of state plus lead:
  - IDLE: B0=B1=0.
    - Synced I=0 -> FILL_BOTH.
    - Else synced S=0 -> FILL_ONE.
    - Else stay.
  - FILL_ONE: only the lead pump on.
    - I=0 -> FILL_BOTH (no min-on check; low level always escalates).
    - S=1 and cnt>=MIN_ON -> IDLE, and lead toggles on that same edge.
    - cnt>=MAX_ONE with S=0 -> FILL_BOTH (assist).
  - FILL_BOTH: B0=B1=1.
    - S=1 and cnt>=MIN_ON -> IDLE, and lead toggles.
    - Else I=1 and cnt>=MIN_ON and entry was from I=0 -> FILL_ONE.
    - Else stay.
    - Assist entries (entry from the MAX_ONE timeout) stay in FILL_BOTH until S=1.
    - One flag bit records the entry reason.
  - ERROR: B0=B1=0, alarm=1.
    - A consistency counter counts consecutive synced samples with no fault (saturates at 3); it clears to 0 on any fault sample.
    - Exit to IDLE when it reaches 3. lead is unchanged.
- alarm=0 in every state except ERROR.
- Reset values: state=IDLE, lead=0, cnt=0, assist flag=0, consistency counter=0, outputB0=0, outputB1=0, alarm=0.

## Timing
- A sensor change set up before edge k appears at the synchronizer output after edge k+1. The state updates on edge k+2, and the outputs change right after edge k+2. Sensor-to-pump latency is 2 cycles.
- Minimum dwell in FILL_ONE or FILL_BOTH before a min-on-qualified exit is MIN_ON+1 cycles. The exit edge is the one where cnt==MIN_ON and the condition holds.
- Assist timeout: entered FILL_ONE at edge e and S stays 0 -> FILL_BOTH on edge e+MAX_ONE+1.
- Simultaneous conditions resolve in this priority order: fault > I=0 escalation > S=1 exit > assist timeout > I=1 de-escalation.
- Reset asserted mid-fill drops both pumps asynchronously. After release, the first decision uses the reset sync values (full), so the controller stays in IDLE for at least 2 edges.
- Outputs are glitch-free and decoded from registers only; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then S=1, I=1 held for 10 cycles -> B0=B1=0, alarm=0, lead=0 throughout.
- From IDLE, drop S=0 with I=1 -> B0=1, B1=0 two edges later. Raise S=1 after 2 cycles -> B0 stays on until cnt=4, then B0=0 and lead=1. Next S=0 -> B1=1, B0=0.
- Fill with S=0, I=1 held for 25 cycles -> lead pump alone for 21 cycles, then B0=B1=1. Set I=1 (already 1) -> both stay on until S=1 and cnt>=4.
- Set I=0, S=0 -> B0=B1=1 after 2 edges. Set I=1 on the next cycle -> both hold until cnt=4, then lead pump only.
- Apply S=1, I=0 during FILL_ONE -> alarm=1 and both pumps off 2 edges later. Restore consistency for 2 samples, inject 1 fault sample, then 3 clean samples -> alarm clears only after the third clean sample; lead unchanged.
- Assert reset during FILL_BOTH -> outputs 0 immediately, without waiting for a clock edge. Release with I=0, S=0 -> IDLE for 2 edges, then B0=B1=1, lead=0.
